kbd_proto: RTL and testbench

KBD_PROTO -- requirements
Module: kbd_proto

---
 rtl/kbd_proto.sv | 240 ++++++++++++++++++++++++
 tb/tb_kbd_proto.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_proto.sv
// Keyboard-side protocol engine: reset handshake with the IOC, paced byte transmit,
// buffered key events and accumulated mouse motion sent as acknowledged byte pairs.
module kbd_proto #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  KBID       = 8'h81,
    parameter logic [15:0] TX_GAP     = 16'd1000
) (
    input  logic       clkcpu,
    input  logic       rst_n,
    input  logic [7:0] kbd_out_data,
    input  logic       kbd_out_strobe,
    output logic [7:0] kbd_in_data,
    output logic       kbd_in_strobe,
    input  logic       key_strobe,
    input  logic [7:0] key_code,
    input  logic       key_up,
    input  logic       mouse_strobe,
    input  logic [7:0] mouse_dx,
    input  logic [7:0] mouse_dy,
    output logic [2:0] leds,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0] HRST = 8'hFF;
    localparam logic [7:0] RAK1 = 8'hFE;
    localparam logic [7:0] RAK2 = 8'hFD;
    localparam logic [7:0] BACK = 8'h3F;
    localparam logic [7:0] RQID = 8'h20;
    localparam logic [7:0] RQMP = 8'h22;

    typedef enum logic [2:0] {
        HS_WAIT_HRST, HS_WAIT_RAK1, HS_WAIT_RAK2, IDLE, WAIT_BACK, WAIT_ACK
    } state_t;

    state_t            state_reg;
    logic              rx_valid_reg;
    logic [7:0]        rx_byte_reg;
    logic              tx_full_reg;
    logic [7:0]        tx_byte_reg;
    logic [15:0]       gap_cnt_reg;
    logic              key_en_reg;
    logic              mouse_en_reg;
    logic [7:0]        pend_byte_reg;
    logic [8:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       fifo_cnt_reg;
    logic signed [6:0] acc_x_reg;
    logic signed [6:0] acc_y_reg;

    logic       rx_go, rx_hrst, is_ack, fifo_empty, fifo_full;
    logic       key_go, mouse_go, rqmp_go, acc_clear, push_ok;
    logic [8:0] head;
    logic [3:0] key_nib;

    // A received byte is only acted on once the holding register is free,
    // so no command can ever need to queue a second byte.
    always_comb begin
        rx_go      = rx_valid_reg && !tx_full_reg;
        rx_hrst    = rx_go && (rx_byte_reg == HRST);
        is_ack     = (rx_byte_reg[7:2] == 6'b001100);
        fifo_empty = (fifo_cnt_reg == '0);
        fifo_full  = (fifo_cnt_reg == DEPTH_C);
        head       = fifo_mem[rd_ptr_reg];
        key_nib    = head[8] ? 4'hD : 4'hC;
        rqmp_go    = rx_go && (state_reg == IDLE) && (rx_byte_reg == RQMP);
        key_go     = (state_reg == IDLE) && !rx_go && !tx_full_reg && key_en_reg && !fifo_empty;
        mouse_go   = (state_reg == IDLE) && !rx_go && !tx_full_reg && mouse_en_reg && !key_go &&
                     ((acc_x_reg != 7'sd0) || (acc_y_reg != 7'sd0));
        acc_clear  = rx_hrst || rqmp_go || mouse_go;
        push_ok    = key_strobe && (!fifo_full || key_go) && !rx_hrst;
    end

    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            rx_valid_reg <= 1'b0;
            rx_byte_reg  <= 8'h00;
        end else if (kbd_out_strobe) begin
            rx_valid_reg <= 1'b1;
            rx_byte_reg  <= kbd_out_data;
        end else if (rx_go) begin
            rx_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clkcpu) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= {key_up, key_code};
    end

    always_ff @(posedge clkcpu) begin
        if (!rst_n || rx_hrst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (key_go)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, key_go})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + (AW+1)'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - (AW+1)'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
        if (!rst_n)
            overflow <= 1'b0;
        else if (key_strobe && fifo_full && !key_go && !rx_hrst)
            overflow <= 1'b1;
    end

    function automatic logic signed [6:0] sat_add(input logic signed [6:0] a, input logic [7:0] d);
        logic signed [8:0] s;
        s = {a[6], a[6], a} + {d[7], d};
        if (s > 9'sd63)
            return 7'h3F;
        else if (s < -9'sd64)
            return 7'h40;
        else
            return s[6:0];
    endfunction

    // A delta arriving in the same cycle as a clear lands on the fresh zero.
    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            acc_x_reg <= 7'sd0;
            acc_y_reg <= 7'sd0;
        end else if (mouse_strobe) begin
            acc_x_reg <= sat_add(acc_clear ? 7'sd0 : acc_x_reg, mouse_dx);
            acc_y_reg <= sat_add(acc_clear ? 7'sd0 : acc_y_reg, mouse_dy);
        end else if (acc_clear) begin
            acc_x_reg <= 7'sd0;
            acc_y_reg <= 7'sd0;
        end
    end

    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            state_reg     <= HS_WAIT_HRST;
            tx_full_reg   <= 1'b0;
            tx_byte_reg   <= 8'h00;
            gap_cnt_reg   <= 16'd0;
            kbd_in_strobe <= 1'b0;
            kbd_in_data   <= 8'h00;
            leds          <= 3'b000;
            key_en_reg    <= 1'b0;
            mouse_en_reg  <= 1'b0;
            pend_byte_reg <= 8'h00;
        end else begin
            kbd_in_strobe <= 1'b0;
            if (gap_cnt_reg != 16'd0)
                gap_cnt_reg <= gap_cnt_reg - 16'd1;
            if (tx_full_reg && gap_cnt_reg == 16'd0) begin
                kbd_in_strobe <= 1'b1;
                kbd_in_data   <= tx_byte_reg;
                tx_full_reg   <= 1'b0;
                gap_cnt_reg   <= TX_GAP - 16'd1;
            end

            if (rx_hrst) begin
                tx_full_reg   <= 1'b1;
                tx_byte_reg   <= HRST;
                state_reg     <= HS_WAIT_RAK1;
                key_en_reg    <= 1'b0;
                mouse_en_reg  <= 1'b0;
                pend_byte_reg <= 8'h00;
            end else if (rx_go) begin
                case (state_reg)
                    HS_WAIT_HRST: ;
                    HS_WAIT_RAK1: begin
                        tx_full_reg <= 1'b1;
                        if (rx_byte_reg == RAK1) begin
                            tx_byte_reg <= RAK1;
                            state_reg   <= HS_WAIT_RAK2;
                        end else begin
                            tx_byte_reg <= HRST;
                        end
                    end
                    HS_WAIT_RAK2: begin
                        tx_full_reg <= 1'b1;
                        if (rx_byte_reg == RAK2) begin
                            tx_byte_reg  <= RAK2;
                            state_reg    <= IDLE;
                            key_en_reg   <= 1'b0;
                            mouse_en_reg <= 1'b0;
                        end else begin
                            tx_byte_reg <= HRST;
                            state_reg   <= HS_WAIT_RAK1;
                        end
                    end
                    IDLE: begin
                        if (is_ack) begin
                            key_en_reg   <= rx_byte_reg[0];
                            mouse_en_reg <= rx_byte_reg[1];
                        end else if (rx_byte_reg[7:3] == 5'd0) begin
                            leds <= rx_byte_reg[2:0];
                        end else if (rx_byte_reg == RQID) begin
                            tx_full_reg <= 1'b1;
                            tx_byte_reg <= KBID;
                        end else if (rx_byte_reg == RQMP) begin
                            tx_full_reg   <= 1'b1;
                            tx_byte_reg   <= {1'b0, acc_x_reg};
                            pend_byte_reg <= {1'b0, acc_y_reg};
                            state_reg     <= WAIT_BACK;
                        end
                    end
                    WAIT_BACK: begin
                        if (rx_byte_reg == BACK) begin
                            tx_full_reg <= 1'b1;
                            tx_byte_reg <= pend_byte_reg;
                            state_reg   <= WAIT_ACK;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    WAIT_ACK: begin
                        if (is_ack) begin
                            key_en_reg   <= rx_byte_reg[0];
                            mouse_en_reg <= rx_byte_reg[1];
                            state_reg    <= IDLE;
                        end
                    end
                    default: state_reg <= HS_WAIT_HRST;
                endcase
            end else if (key_go) begin
                tx_full_reg   <= 1'b1;
                tx_byte_reg   <= {key_nib, head[7:4]};
                pend_byte_reg <= {key_nib, head[3:0]};
                state_reg     <= WAIT_BACK;
            end else if (mouse_go) begin
                tx_full_reg   <= 1'b1;
                tx_byte_reg   <= {1'b0, acc_x_reg};
                pend_byte_reg <= {1'b0, acc_y_reg};
                state_reg     <= WAIT_BACK;
            end
        end
    end
endmodule

// File: tb/tb_kbd_proto.sv
// Bench for kbd_proto: command table, hand-written pair/handshake sequences and
// randomized key/mouse rounds checked against a queue/integer model of the protocol.
module tb_kbd_proto;
    localparam int GAP   = 20;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] kbd_out_data = 8'h00;
    logic       kbd_out_strobe = 1'b0;
    logic [7:0] kbd_in_data;
    logic       kbd_in_strobe;
    logic       key_strobe = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_up = 1'b0;
    logic       mouse_strobe = 1'b0;
    logic [7:0] mouse_dx = 8'h00;
    logic [7:0] mouse_dy = 8'h00;
    logic [2:0] leds;
    logic       overflow;

    kbd_proto #(.FIFO_DEPTH(DEPTH), .KBID(8'h81), .TX_GAP(16'(GAP))) dut (
        .clkcpu(clk), .rst_n(rst_n),
        .kbd_out_data(kbd_out_data), .kbd_out_strobe(kbd_out_strobe),
        .kbd_in_data(kbd_in_data), .kbd_in_strobe(kbd_in_strobe),
        .key_strobe(key_strobe), .key_code(key_code), .key_up(key_up),
        .mouse_strobe(mouse_strobe), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
        .leds(leds), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_strobe = 0;
    bit         have_last = 0;
    logic [7:0] txq[$];
    logic [8:0] kq[$];
    bit         movf = 0;
    int         mx = 0;
    int         my = 0;

    typedef struct {
        logic [7:0] rx;
        bit         resp;
        logic [7:0] tx;
        logic [2:0] leds;
    } vec_t;
    vec_t tbl [16];

    always @(posedge clk) cyc++;

    // Collect every transmitted byte and check the spacing between strobes.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_last = 0;
        end else if (kbd_in_strobe) begin
            txq.push_back(kbd_in_data);
            if (have_last) begin
                checks++;
                if (cyc - last_strobe < GAP) begin
                    errors++;
                    $display("FAIL tx_gap: got %0d cycles required >= %0d", cyc - last_strobe, GAP);
                end
            end
            have_last = 1;
            last_strobe = cyc;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int clamp(input int v);
        return (v > 63) ? 63 : ((v < -64) ? -64 : v);
    endfunction

    function automatic logic [7:0] mbyte(input int v);
        logic [7:0] t;
        t = 8'(v);
        return {1'b0, t[6:0]};
    endfunction

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h required %02h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        kbd_out_data = b;
        kbd_out_strobe = 1'b1;
        @(negedge clk);
        kbd_out_strobe = 1'b0;
        $display("rx %02h", b);
    endtask

    task automatic expect_tx(input string name, input logic [7:0] exp);
        int n = 0;
        logic [7:0] got;
        while (txq.size() == 0 && n < 4 * GAP + 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txq.size() == 0) begin
            errors++;
            $display("FAIL %s: no byte after %0d cycles, required %02h", name, n, exp);
        end else begin
            got = txq.pop_front();
            $display("tx %s %02h", name, got);
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %02h required %02h", name, got, exp);
            end
        end
    endtask

    task automatic expect_quiet(input string name, input int n);
        repeat (n) @(negedge clk);
        checks++;
        if (txq.size() != 0) begin
            errors++;
            $display("FAIL %s: got byte %02h required none", name, txq[0]);
            txq.delete();
        end
    endtask

    task automatic press(input logic [7:0] code, input logic up);
        @(negedge clk);
        key_code = code;
        key_up = up;
        key_strobe = 1'b1;
        @(negedge clk);
        key_strobe = 1'b0;
        $display("key %02h up=%0d", code, up);
    endtask

    task automatic press_model(input logic [7:0] code, input logic up);
        press(code, up);
        if (kq.size() < DEPTH) kq.push_back({up, code});
        else movf = 1;
    endtask

    task automatic mouse(input int dx, input int dy);
        @(negedge clk);
        mouse_dx = 8'(dx);
        mouse_dy = 8'(dy);
        mouse_strobe = 1'b1;
        @(negedge clk);
        mouse_strobe = 1'b0;
        mx = clamp(mx + dx);
        my = clamp(my + dy);
        $display("mouse dx=%0d dy=%0d", dx, dy);
    endtask

    task automatic drain();
        logic [8:0] e;
        logic [3:0] nib;
        while (kq.size() > 0) begin
            e = kq.pop_front();
            nib = e[8] ? 4'hD : 4'hC;
            expect_tx("key_first", {nib, e[7:4]});
            send(8'h3F);
            expect_tx("key_second", {nib, e[3:0]});
            send(8'h31);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        txq.delete();
        kq.delete();
        movf = 0;
        mx = 0;
        my = 0;
    endtask

    initial begin
        tbl[0]  = '{8'h12, 1'b0, 8'h00, 3'd0};
        tbl[1]  = '{8'hFF, 1'b1, 8'hFF, 3'd0};
        tbl[2]  = '{8'h00, 1'b1, 8'hFF, 3'd0};
        tbl[3]  = '{8'hFE, 1'b1, 8'hFE, 3'd0};
        tbl[4]  = '{8'h11, 1'b1, 8'hFF, 3'd0};
        tbl[5]  = '{8'hFE, 1'b1, 8'hFE, 3'd0};
        tbl[6]  = '{8'hFD, 1'b1, 8'hFD, 3'd0};
        tbl[7]  = '{8'h05, 1'b0, 8'h00, 3'd5};
        tbl[8]  = '{8'h20, 1'b1, 8'h81, 3'd5};
        tbl[9]  = '{8'h22, 1'b1, 8'h00, 3'd5};
        tbl[10] = '{8'h3F, 1'b1, 8'h00, 3'd5};
        tbl[11] = '{8'h07, 1'b0, 8'h00, 3'd5};
        tbl[12] = '{8'h30, 1'b0, 8'h00, 3'd5};
        tbl[13] = '{8'h02, 1'b0, 8'h00, 3'd2};
        tbl[14] = '{8'h06, 1'b0, 8'h00, 3'd6};
        tbl[15] = '{8'h20, 1'b1, 8'h81, 3'd6};

        // Reset state
        repeat (3) @(negedge clk);
        check8("rst_strobe", {7'd0, kbd_in_strobe}, 8'h00);
        check8("rst_data", kbd_in_data, 8'h00);
        check8("rst_leds", {5'd0, leds}, 8'h00);
        check8("rst_overflow", {7'd0, overflow}, 8'h00);
        rst_n = 1'b1;

        // Handshake, LEDS, RQID, RQMP and acknowledge commands
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].rx);
            if (tbl[i].resp) expect_tx("table_tx", tbl[i].tx);
            else expect_quiet("table_quiet", 10);
            check8("table_leds", {5'd0, leds}, {5'd0, tbl[i].leds});
        end

        // Key pair sequence
        send(8'h33);
        expect_quiet("smak_idle", 10);
        press(8'h25, 1'b0);
        expect_tx("press_first", 8'hC2);
        send(8'h3F);
        expect_tx("press_second", 8'hC5);
        send(8'h31);
        mouse(5, 0);
        expect_quiet("mouse_disabled", 3 * GAP);
        press(8'h3A, 1'b1);
        expect_tx("release_first", 8'hD3);
        send(8'h3F);
        expect_tx("release_second", 8'hDA);
        send(8'h31);

        // Mouse saturation
        mouse(100, 0);
        mouse(10, -3);
        send(8'h32);
        expect_tx("mouse_x_sat", mbyte(mx));
        send(8'h3F);
        expect_tx("mouse_y", mbyte(my));
        mx = 0;
        my = 0;
        send(8'h30);
        expect_quiet("nack_idle", 10);

        // Randomized rounds against the queue/integer model
        for (int r = 0; r < 6; r++) begin
            int nk, nm;
            nk = $urandom_range(0, 10);
            nm = $urandom_range(0, 3);
            for (int k = 0; k < nk; k++)
                press_model(8'($urandom), 1'($urandom));
            for (int m = 0; m < nm; m++)
                mouse($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
            repeat (2) @(negedge clk);
            check8("rand_overflow", {7'd0, overflow}, {7'd0, movf});
            send(8'h31);
            drain();
            expect_quiet("rand_drained", 30);
            send(8'h30);
            send(8'h22);
            expect_tx("rqmp_x", mbyte(mx));
            send(8'h3F);
            expect_tx("rqmp_y", mbyte(my));
            mx = 0;
            my = 0;
            send(8'h30);
            expect_quiet("rand_end", 10);
        end

        // Overflow with nine presses into eight entries
        do_reset();
        check8("ovf_after_reset", {7'd0, overflow}, 8'h00);
        send(8'hFF); expect_tx("hs_ff", 8'hFF);
        send(8'hFE); expect_tx("hs_fe", 8'hFE);
        send(8'hFD); expect_tx("hs_fd", 8'hFD);
        for (int i = 0; i < 9; i++)
            press_model(8'(8'h10 + 8'(i * 17)), 1'b0);
        repeat (2) @(negedge clk);
        check8("ovf_set", {7'd0, overflow}, 8'h01);
        send(8'h31);
        drain();
        expect_quiet("ninth_absent", 60);

        // HRST during WAIT_BACK flushes queued events
        press(8'h47, 1'b0);
        expect_tx("hrst_first", 8'hC4);
        press(8'h11, 1'b0);
        press(8'h22, 1'b1);
        send(8'hFF);
        expect_tx("hrst_mid_back", 8'hFF);
        send(8'hFE); expect_tx("rehs_fe", 8'hFE);
        send(8'hFD); expect_tx("rehs_fd", 8'hFD);
        send(8'h31);
        expect_quiet("fifo_flushed", 3 * GAP);

        // Non-BACK byte in WAIT_BACK discards the pair without acting on it
        press(8'h11, 1'b0);
        expect_tx("discard_first", 8'hC1);
        send(8'h05);
        expect_quiet("discard_quiet", 3 * GAP);
        check8("discard_leds", {5'd0, leds}, 8'h00);
        send(8'h20);
        expect_tx("rqid_after_discard", 8'h81);

        // Reset while a byte is held back by the gap
        send(8'h20);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("held_abandoned", 3 * GAP);
        check8("held_data", kbd_in_data, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
